// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - receiver FSM states, parity encodings and baud divisor table
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DIV_W = 24;

  function automatic int unsigned baud_rate(input int idx);
    case (idx)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded clocks per oversample tick; never below 1 so the counter always wraps.
  function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_freq,
                                                    input int unsigned oversample,
                                                    input int idx);
    int unsigned denom;
    int unsigned q;
    denom = baud_rate(idx) * oversample;
    q = (clk_freq + denom / 2) / denom;
    if (q == 0) q = 1;
    return DIV_W'(q);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator; divisor is re-latched on each wrap
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select_i,
  output logic       tick_o
);

  logic [DIV_W-1:0] div_tab [8];
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  for (genvar g = 0; g < 8; g++) begin : g_tab
    assign div_tab[g] = baud_divisor(CLK_FREQ, OVERSAMPLE, g);
  end

  // Divisor starts at 1 so the real value is loaded on the first clock after reset.
  assign tick   = (cnt_q >= div_q - DIV_W'(1));
  assign tick_o = tick;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    div_d = tick ? div_tab[baud_select_i] : div_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= DIV_W'(1);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver, 5..9 data bits, parity, 1/2 stop bits
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling around mid-bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_en,
  input  logic                 rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perror,
  output logic                 rx_ferror,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] S_DECIDE = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] S_DECIDE = SW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [3:0] B_LAST = 4'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q;
  logic                 prev_q, prev_d;
  logic [SW-1:0]        s_q, s_d;
  logic [3:0]           b_q, b_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perror_q, perror_d;
  logic                 ferror_q, ferror_d, overrun_q, overrun_d;
  logic                 tick, rxd_s, sample, mid, last, complete, par_en;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clock        (clock),
    .reset        (reset),
    .baud_select_i(baud_select),
    .tick_o       (tick)
  );

  assign rxd_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] S_H0 = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] S_H1 = SW'(OVERSAMPLE / 2 - 1);
  logic [1:0] hist_q, hist_d;

  assign hist_d = (tick && (s_q == S_H0 || s_q == S_H1)) ? {hist_q[0], rxd_s} : hist_q;
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end
`else
  assign sample = rxd_s;
`endif

  assign mid    = tick && (s_q == S_DECIDE);
  assign last   = tick && (s_q == S_LAST);
  assign par_en = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    b_d      = b_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    complete = 1'b0;
    prev_d   = tick ? rxd_s : prev_q;
    if (tick) s_d = last ? '0 : s_q + SW'(1);

    case (state_q)
      ST_IDLE: begin
        s_d = '0;
        // Start edge is seen between two consecutive tick samples.
        if (tick && rx_en && prev_q && !rxd_s) begin
          state_d = ST_START;
          b_d     = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (mid && sample) state_d = ST_IDLE;
        else if (last)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (mid) shift_d = {sample, shift_q[DATA_BITS-1:1]};
        if (last) begin
          if (b_q == B_LAST) begin
            b_d     = '0;
            state_d = par_en ? ST_PARITY : ST_STOP;
          end else begin
            b_d = b_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (mid)  perr_d = (^shift_q) ^ sample ^ (parity_mode == PAR_ODD);
        if (last) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (mid) begin
          ferr_d = ferr_q | ~sample;
          if (b_q == {3'b000, two_stop}) begin
            complete = rx_en;
            state_d  = ST_IDLE;
          end
        end else if (last) begin
          b_d = b_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_en) state_d = ST_IDLE;

    data_d    = data_q;
    valid_d   = valid_q;
    perror_d  = perror_q;
    ferror_d  = ferror_q;
    overrun_d = overrun_q;
    if (complete) begin
      data_d    = shift_q;
      perror_d  = perr_q;
      ferror_d  = ferr_d;
      valid_d   = ~perr_q & ~ferr_d;
      overrun_d = rx_ack ? 1'b0 : (overrun_q | valid_q | perror_q | ferror_q);
    end else if (rx_ack) begin
      valid_d   = 1'b0;
      perror_d  = 1'b0;
      ferror_d  = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      s_q       <= '0;
      b_q       <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perror_q  <= 1'b0;
      ferror_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], rxd};
      prev_q    <= prev_d;
      s_q       <= s_d;
      b_q       <= b_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perror_q  <= perror_d;
      ferror_q  <= ferror_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_perror  = perror_q;
  assign rx_ferror  = ferror_q;
  assign rx_overrun = overrun_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule
